// File: rtl/ow_bus_monitor.sv
// ow_bus_monitor: passive 1-Wire decoder that turns low-pulse widths into reset, presence and bit slots.
// Optional macro OW_MON_SEARCH_EN decodes Search ROM (F0h) triplets into ROMID.
`timescale 1ns/1ps
module ow_bus_monitor #(
  parameter int CLKS_PER_US = 32,
  parameter int GLITCH_US   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ow_in,
  output logic        reset_det,
  output logic        presence_det,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        data_valid,
  output logic [7:0]  data_byte,
  output logic        romid_valid,
  output logic [63:0] romid,
  output logic        err
);

  localparam int WMAX = 1023 * CLKS_PER_US;
  localparam int WW   = $clog2(WMAX + 1);
  localparam logic [WW-1:0] W_MAX    = WW'(WMAX);
  localparam logic [WW-1:0] W_GLITCH = WW'(GLITCH_US * CLKS_PER_US);
  localparam logic [WW-1:0] W_BIT0   = WW'(15 * CLKS_PER_US);
  localparam logic [WW-1:0] W_ERR    = WW'(120 * CLKS_PER_US);
  localparam logic [WW-1:0] W_RESET  = WW'(480 * CLKS_PER_US);
  localparam logic [WW-1:0] W_PMIN   = WW'(60 * CLKS_PER_US);
  localparam logic [WW-1:0] W_PMAX   = WW'(240 * CLKS_PER_US);
  localparam logic [WW-1:0] W_PWIN   = WW'(300 * CLKS_PER_US);

  typedef enum logic [2:0] {
    S_IDLE, S_PRES_WAIT, S_ROM_CMD, S_ROMID, S_DATA, S_SEARCH
  } state_t;

  state_t          state, state_next;
  logic [1:0]      sync;
  logic            line, line_q, fall, rise;
  logic [WW-1:0]   width, timer;
  logic [5:0]      bit_cnt;
  logic [1:0]      slot;
  logic            true_bit;
  logic [63:0]     shreg;
  logic [7:0]      rx_byte;
  logic            pulse_end, is_reset, is_err_w, is_bit, bit_val, pres_ok, pres_timeout;
  logic            cmd_fire, data_fire, romid_fire, err_set, pres_set, bit_adv;

  assign line = sync[1];
  assign fall = line_q & ~line;
  assign rise = ~line_q & line;

  // Synchroniser flops idle high so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= 2'b11;
      line_q <= 1'b1;
    end else begin
      sync   <= {sync[0], ow_in};
      line_q <= sync[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width <= '0;
      timer <= '0;
    end else begin
      if (fall)
        width <= WW'(1);
      else if (!line && width != W_MAX)
        width <= width + WW'(1);
      if (is_reset)
        timer <= '0;
      else if (state == S_PRES_WAIT && timer != W_PWIN)
        timer <= timer + WW'(1);
    end
  end

  assign pulse_end    = rise && (width >= W_GLITCH);
  assign is_reset     = pulse_end && (width >= W_RESET);
  assign is_err_w     = pulse_end && (width >= W_ERR) && (width < W_RESET);
  assign is_bit       = pulse_end && (width < W_ERR);
  assign bit_val      = (width < W_BIT0);
  assign pres_ok      = (width >= W_PMIN) && (width <= W_PMAX);
  assign pres_timeout = (state == S_PRES_WAIT) && line && !rise && (timer >= W_PWIN);
  assign rx_byte      = {bit_val, shreg[63:57]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (is_reset) begin
      state_next = S_PRES_WAIT;
    end else begin
      case (state)
        S_PRES_WAIT: begin
          if (pulse_end)         state_next = pres_ok ? S_ROM_CMD : S_IDLE;
          else if (pres_timeout) state_next = S_IDLE;
        end
        S_ROM_CMD: begin
          if (is_err_w) state_next = S_IDLE;
          else if (is_bit && bit_cnt == 6'd7) begin
            case (rx_byte)
              8'h55, 8'h33: state_next = S_ROMID;
`ifdef OW_MON_SEARCH_EN
              8'hF0:        state_next = S_SEARCH;
`else
              8'hF0:        state_next = S_IDLE;
`endif
              default:      state_next = S_DATA;
            endcase
          end
        end
        S_ROMID: begin
          if (is_err_w) state_next = S_IDLE;
          else if (is_bit && bit_cnt == 6'd63) state_next = S_DATA;
        end
        S_DATA: begin
          if (is_err_w) state_next = S_IDLE;
        end
        S_SEARCH: begin
          if (is_err_w) state_next = S_IDLE;
          else if (is_bit && slot == 2'd1 && true_bit && bit_val) state_next = S_IDLE;
          else if (is_bit && slot == 2'd2 && bit_cnt == 6'd63) state_next = S_DATA;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_fire   = 1'b0;
    data_fire  = 1'b0;
    romid_fire = 1'b0;
    err_set    = 1'b0;
    pres_set   = 1'b0;
    bit_adv    = 1'b0;
    case (state)
      S_PRES_WAIT: begin
        if (pulse_end && !is_reset) begin
          pres_set = pres_ok;
          err_set  = !pres_ok;
        end else if (pres_timeout) begin
          err_set = 1'b1;
        end
      end
      S_ROM_CMD: if (is_bit) begin
        bit_adv = 1'b1;
        if (bit_cnt == 6'd7) begin
          cmd_fire = 1'b1;
          err_set  = !(rx_byte inside {8'h55, 8'h33, 8'hCC, 8'hF0});
        end
      end
      S_ROMID: if (is_bit) begin
        bit_adv    = 1'b1;
        romid_fire = (bit_cnt == 6'd63);
      end
      S_DATA: if (is_bit) begin
        bit_adv   = 1'b1;
        data_fire = (bit_cnt[2:0] == 3'd7);
      end
      S_SEARCH: if (is_bit) begin
        // Triplet: true bit, complement, then the master's chosen direction.
        if (slot == 2'd1 && true_bit && bit_val) err_set = 1'b1;
        if (slot == 2'd2) begin
          bit_adv    = 1'b1;
          romid_fire = (bit_cnt == 6'd63);
        end
      end
      default: ;
    endcase
    if (is_err_w && state != S_PRES_WAIT) err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reset_det    <= 1'b0;
      presence_det <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_byte     <= '0;
      data_valid   <= 1'b0;
      data_byte    <= '0;
      romid_valid  <= 1'b0;
      romid        <= '0;
      err          <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      slot         <= '0;
      true_bit     <= 1'b0;
    end else begin
      reset_det   <= is_reset;
      cmd_valid   <= cmd_fire;
      data_valid  <= data_fire;
      romid_valid <= romid_fire;
      if (cmd_fire)   cmd_byte  <= rx_byte;
      if (data_fire)  data_byte <= rx_byte;
      if (romid_fire) romid     <= {bit_val, shreg[63:1]};
      if (err_set)    err       <= 1'b1;
      if (is_reset)      presence_det <= 1'b0;
      else if (pres_set) presence_det <= 1'b1;
      if (is_reset)     shreg <= '0;
      else if (bit_adv) shreg <= {bit_val, shreg[63:1]};
      if (is_reset || state_next != state) begin
        bit_cnt <= '0;
        slot    <= '0;
      end else begin
        if (bit_adv) bit_cnt <= bit_cnt + 6'd1;
        if (state == S_SEARCH && is_bit) slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
      end
      if (state == S_SEARCH && is_bit && slot == 2'd0) true_bit <= bit_val;
    end
  end

endmodule
